// File: rtl/svm_req_rx.sv
// svm_req_rx: receive endpoint between the ROM DMA request stream and svm_core.
// Ports: clk/reset; req_vld/req_data in from the DMA; svm_fifo_full back to the DMA;
// vec_vld/vec_data/vec_idx/vec_last/vec_ready toward the core; rec_count,
// overflow_err, clr_stats and fifo_empty for status.
module svm_req_rx #(
    parameter int IEEE_32BIT   = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int FULL_MARGIN  = 2,
    parameter int NUM_FEATURES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_vld,
    input  logic [IEEE_32BIT-1:0] req_data,
    output logic                  svm_fifo_full,
    output logic                  vec_vld,
    output logic [IEEE_32BIT-1:0] vec_data,
    output logic [((NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1)-1:0] vec_idx,
    output logic                  vec_last,
    input  logic                  vec_ready,
    output logic [15:0]           rec_count,
    output logic                  overflow_err,
    input  logic                  clr_stats,
    output logic                  fifo_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int IW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [OW-1:0] DEPTH   = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0] THRESH  = OW'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [IW-1:0] IDX_PEN = IW'(NUM_FEATURES - 2);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_FEATURES - 1);
    localparam logic          LAST_RST = (NUM_FEATURES == 1);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_MID,
        ST_LAST
    } state_t;

    logic [IEEE_32BIT-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [OW-1:0]         occ;
    logic [OW-1:0]         occ_nxt;
    logic                  reg_free;
    logic                  pop;
    logic                  bypass;
    logic                  push;
    logic                  drop;
    logic                  hs;
    logic                  rec_done;
    state_t                state;

    always_comb begin
        hs       = vec_vld && vec_ready;
        reg_free = !vec_vld || vec_ready;
        pop      = reg_free && (occ != '0);
        // An empty FIFO lets the word skip storage and land in the output register.
        bypass   = reg_free && (occ == '0) && req_vld;
        push     = req_vld && !bypass && (occ != DEPTH);
        drop     = req_vld && (occ == DEPTH);
        // vec_last is high exactly on the closing word of a record.
        rec_done = hs && vec_last;
        occ_nxt  = occ;
        if (push && !pop) begin
            occ_nxt = occ + OW'(1);
        end else if (pop && !push) begin
            occ_nxt = occ - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            svm_fifo_full <= 1'b0;
            fifo_empty    <= 1'b1;
            vec_vld       <= 1'b0;
            vec_data      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occ           <= occ_nxt;
            svm_fifo_full <= (occ_nxt >= THRESH);
            fifo_empty    <= (occ_nxt == '0);
            if (reg_free) begin
                vec_vld <= pop || bypass;
            end
            if (pop) begin
                vec_data <= mem[rd_ptr];
            end else if (bypass) begin
                vec_data <= req_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_FIRST;
            vec_idx      <= '0;
            vec_last     <= LAST_RST;
            rec_count    <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (hs) begin
                unique case (state)
                    ST_FIRST: begin
                        if (NUM_FEATURES == 2) begin
                            state    <= ST_LAST;
                            vec_idx  <= IDX_MAX;
                            vec_last <= 1'b1;
                        end else if (NUM_FEATURES > 2) begin
                            state   <= ST_MID;
                            vec_idx <= IW'(1);
                        end
                    end
                    ST_MID: begin
                        vec_idx <= vec_idx + IW'(1);
                        if (vec_idx == IDX_PEN) begin
                            state    <= ST_LAST;
                            vec_last <= 1'b1;
                        end
                    end
                    ST_LAST: begin
                        state    <= ST_FIRST;
                        vec_idx  <= '0;
                        vec_last <= 1'b0;
                    end
                    default: begin
                        state    <= ST_FIRST;
                        vec_idx  <= '0;
                        vec_last <= LAST_RST;
                    end
                endcase
            end
            if (clr_stats) begin
                rec_count <= '0;
            end else if (rec_done) begin
                rec_count <= rec_count + 16'd1;
            end
            if (clr_stats) begin
                overflow_err <= 1'b0;
            end else if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
